// File: rtl/alert_dispatch_ack_pkg.sv
// Shared definitions for the alert dispatch path.
//   chan_state_e : per-channel delivery FSM states
//   CH_*         : bit index of each notification channel in the alert vectors
//   NUM_CH       : number of notification channels
package alert_pkg;

  localparam int unsigned NUM_CH   = 3;
  localparam int unsigned CH_APP   = 0;
  localparam int unsigned CH_EMAIL = 1;
  localparam int unsigned CH_SMS   = 2;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    BACKOFF,
    DONE,
    FAIL
  } chan_state_e;

endpackage

// File: rtl/alert_dispatch_ack_if.sv
// Request/acknowledge bundle between the dispatcher and the channel logic
// (app gateway, mail relay, SMS modem). One bit per channel, indexed by CH_*.
//   ch_req : delivery request, driven by the dispatcher (master)
//   ch_ack : single-cycle delivery acknowledge, driven by the channel (slave)
interface alert_dispatch_ack_if import alert_pkg::*; ();

  logic [NUM_CH-1:0] ch_req;
  logic [NUM_CH-1:0] ch_ack;

  modport master (output ch_req, input ch_ack);
  modport slave  (input ch_req, output ch_ack);

endinterface

// File: rtl/alert_dispatch_ack_channel_fsm.sv
// One notification channel: rising-edge detect on its alert level, req/ack
// delivery with per-attempt timeout, backoff between attempts, bounded retries,
// and sticky delivered/failed status.
//   clk, rst_n  : clock, asynchronous active-low reset
//   alert       : alert level for this channel
//   user_clear  : returns the channel to IDLE and clears the sticky bits
//   ack         : delivery acknowledge pulse from the channel
//   req         : registered delivery request
//   delivered   : sticky success
//   failed      : sticky failure (all attempts timed out)
//   busy        : channel is in REQ or BACKOFF
module alert_channel_fsm import alert_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned BACKOFF_CYCLES = 250,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned CNT_W          = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic alert,
  input  logic user_clear,
  input  logic ack,
  output logic req,
  output logic delivered,
  output logic failed,
  output logic busy
);

  localparam int unsigned ATT_W = $clog2(MAX_RETRIES + 1) + 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BO_LAST = CNT_W'(BACKOFF_CYCLES - 1);
  localparam logic [ATT_W-1:0] ATT_MAX = ATT_W'(MAX_RETRIES);

  chan_state_e      state, state_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic [ATT_W-1:0] attempt, attempt_n;
  logic             delivered_n, failed_n;
  logic             prev;
  logic             armed;
  logic             trigger;

  // prev is cleared by reset, so a level already high when reset releases
  // would look like a fresh edge. armed suppresses triggers until one edge
  // has been sampled out of reset, forcing a real 0->1 transition first.
  assign trigger = alert & ~prev & armed;

  always_comb begin
    state_n     = state;
    timer_n     = timer;
    attempt_n   = attempt;
    delivered_n = delivered;
    failed_n    = failed;

    if (user_clear) begin
      state_n     = IDLE;
      timer_n     = '0;
      attempt_n   = '0;
      delivered_n = 1'b0;
      failed_n    = 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE, FAIL: begin
          if (trigger) begin
            state_n   = REQ;
            timer_n   = '0;
            attempt_n = '0;
          end
        end
        REQ: begin
          // Ack is checked first so it wins over a coincident timeout.
          if (ack) begin
            state_n     = DONE;
            timer_n     = '0;
            delivered_n = 1'b1;
          end else if (timer == TO_LAST) begin
            timer_n = '0;
            if (attempt == ATT_MAX) begin
              state_n  = FAIL;
              failed_n = 1'b1;
            end else begin
              state_n   = BACKOFF;
              attempt_n = attempt + ATT_W'(1);
            end
          end else begin
            timer_n = timer + CNT_W'(1);
          end
        end
        BACKOFF: begin
          if (timer == BO_LAST) begin
            state_n = REQ;
            timer_n = '0;
          end else begin
            timer_n = timer + CNT_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      attempt   <= '0;
      delivered <= 1'b0;
      failed    <= 1'b0;
      req       <= 1'b0;
      prev      <= 1'b0;
      armed     <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      attempt   <= attempt_n;
      delivered <= delivered_n;
      failed    <= failed_n;
      req       <= (state_n == REQ);
      prev      <= alert;
      armed     <= 1'b1;
    end
  end

  assign busy = (state == REQ) || (state == BACKOFF);

endmodule

// File: rtl/alert_dispatch_ack.sv
// Alert dispatcher: delivers each rising alert level to its notification
// channel over req/ack, supervising every channel independently.
//   clk, rst_n  : clock, asynchronous active-low reset
//   alert_in    : alert levels (CH_APP, CH_EMAIL, CH_SMS)
//   user_clear  : pulse; clears all channel state and status
//   chan        : per-channel ch_req (out) / ch_ack (in)
//   delivered   : sticky per-channel success
//   failed      : sticky per-channel failure
//   escalate    : registered OR of failed
//   busy        : any channel in REQ or BACKOFF
module alert_dispatch_ack import alert_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned BACKOFF_CYCLES = 250,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    alert_in,
  input  logic                 user_clear,
  alert_dispatch_ack_if.master chan,
  output logic [NUM_CH-1:0]    delivered,
  output logic [NUM_CH-1:0]    failed,
  output logic                 escalate,
  output logic                 busy
);

  localparam int unsigned CNT_W =
    $clog2((TIMEOUT_CYCLES > BACKOFF_CYCLES) ? TIMEOUT_CYCLES : BACKOFF_CYCLES) + 1;

  logic [NUM_CH-1:0] req_v;
  logic [NUM_CH-1:0] busy_v;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    alert_channel_fsm #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .BACKOFF_CYCLES (BACKOFF_CYCLES),
      .MAX_RETRIES    (MAX_RETRIES),
      .CNT_W          (CNT_W)
    ) u_fsm (
      .clk        (clk),
      .rst_n      (rst_n),
      .alert      (alert_in[i]),
      .user_clear (user_clear),
      .ack        (chan.ch_ack[i]),
      .req        (req_v[i]),
      .delivered  (delivered[i]),
      .failed     (failed[i]),
      .busy       (busy_v[i])
    );
  end

  assign chan.ch_req = req_v;
  assign busy        = |busy_v;

  // Cleared directly by user_clear so it drops on the same edge as failed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      escalate <= 1'b0;
    end else if (user_clear) begin
      escalate <= 1'b0;
    end else begin
      escalate <= |failed;
    end
  end

endmodule
